// File: rtl/execute_stage.sv
// Execute stage: single-cycle ALU plus iterative 32-cycle MULTU/DIVU writing HI/LO.
// Results, zero flag and pipeline controls are registered toward memory_access.
module execute_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  input  logic        flush,
  input  logic [3:0]  alu_op,
  input  logic [31:0] read_data_1,
  input  logic [31:0] read_data_2,
  input  logic [31:0] sign_ext_imm,
  input  logic [4:0]  shamt,
  input  logic        ctrl_aluSrc,
  input  logic        ctrl_branch_in,
  input  logic        ctrl_memRead_in,
  input  logic        ctrl_memWrite_in,
  input  logic        ctrl_regWrite_in,
  input  logic        ctrl_memToReg_in,
  input  logic [4:0]  write_reg_in,
  output logic        busy,
  output logic        out_valid,
  output logic [31:0] mem_address,
  output logic        zero,
  output logic [31:0] write_data_into_mem,
  output logic        ctrl_branch,
  output logic        ctrl_memRead,
  output logic        ctrl_memWrite,
  output logic        ctrl_regWrite,
  output logic        ctrl_memToReg,
  output logic [4:0]  write_reg
);

  localparam logic [3:0] OpAnd  = 4'b0000;
  localparam logic [3:0] OpOr   = 4'b0001;
  localparam logic [3:0] OpAdd  = 4'b0010;
  localparam logic [3:0] OpSll  = 4'b0011;
  localparam logic [3:0] OpSrl  = 4'b0100;
  localparam logic [3:0] OpSra  = 4'b0101;
  localparam logic [3:0] OpSub  = 4'b0110;
  localparam logic [3:0] OpSlt  = 4'b0111;
  localparam logic [3:0] OpMulu = 4'b1000;
  localparam logic [3:0] OpDivu = 4'b1001;
  localparam logic [3:0] OpMfhi = 4'b1010;
  localparam logic [3:0] OpMflo = 4'b1011;
  localparam logic [3:0] OpNor  = 4'b1100;

  typedef enum logic [1:0] {StIdle, StMul, StDiv} state_e;

  state_e      state_q;
  logic [5:0]  cnt_q;
  logic [31:0] hi_q, lo_q;
  logic [63:0] acc_q;
  logic [31:0] opb_q;
  logic        busy_q, out_valid_q, zero_q;
  logic [31:0] result_q, wdata_q, pend_wdata_q;
  logic [4:0]  ctrl_q, pend_ctrl_q;
  logic [4:0]  wreg_q, pend_wreg_q;

  logic [31:0] op_b, alu_res;
  logic [32:0] mul_sum, div_cand;
  logic [31:0] div_sub;
  logic        div_ge;
  logic [63:0] step_next;
  logic        accept, is_multi, last_iter;
  logic [4:0]  ctrl_in;

  assign op_b      = ctrl_aluSrc ? sign_ext_imm : read_data_2;
  assign is_multi  = (alu_op == OpMulu) || (alu_op == OpDivu);
  assign accept    = in_valid && !busy_q;
  assign last_iter = (cnt_q == 6'd31);
  assign ctrl_in   = {ctrl_branch_in, ctrl_memRead_in, ctrl_memWrite_in, ctrl_regWrite_in,
                      ctrl_memToReg_in};

  always_comb begin
    alu_res = '0;
    case (alu_op)
      OpAnd:   alu_res = read_data_1 & op_b;
      OpOr:    alu_res = read_data_1 | op_b;
      OpAdd:   alu_res = read_data_1 + op_b;
      OpSub:   alu_res = read_data_1 - op_b;
      OpSlt:   alu_res = {31'b0, $signed(read_data_1) < $signed(op_b)};
      OpNor:   alu_res = ~(read_data_1 | op_b);
      OpSll:   alu_res = op_b << shamt;
      OpSrl:   alu_res = op_b >> shamt;
      OpSra:   alu_res = $signed(op_b) >>> shamt;
      OpMfhi:  alu_res = hi_q;
      OpMflo:  alu_res = lo_q;
      default: alu_res = '0;
    endcase
  end

  // acc_q holds {partial product, multiplier} for MUL and {remainder, dividend/quotient} for DIV,
  // so both finish with HI in [63:32] and LO in [31:0].
  always_comb begin
    mul_sum  = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opb_q} : 33'd0);
    div_cand = acc_q[63:31];
    div_ge   = div_cand >= {1'b0, opb_q};
    div_sub  = div_cand[31:0] - opb_q;
    if (state_q == StMul) begin
      step_next = {mul_sum, acc_q[31:1]};
    end else begin
      step_next = {(div_ge ? div_sub : div_cand[31:0]), acc_q[30:0], div_ge};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      hi_q         <= '0;
      lo_q         <= '0;
      acc_q        <= '0;
      opb_q        <= '0;
      busy_q       <= 1'b0;
      out_valid_q  <= 1'b0;
      zero_q       <= 1'b0;
      result_q     <= '0;
      wdata_q      <= '0;
      ctrl_q       <= '0;
      wreg_q       <= '0;
      pend_wdata_q <= '0;
      pend_ctrl_q  <= '0;
      pend_wreg_q  <= '0;
    end else if (flush) begin
      state_q       <= StIdle;
      cnt_q         <= '0;
      busy_q        <= 1'b0;
      out_valid_q   <= 1'b0;
      ctrl_q[4:1]   <= '0;
    end else begin
      // Without a fresh result the side-effecting controls drop; data outputs hold.
      out_valid_q <= 1'b0;
      ctrl_q[4:1] <= '0;
      unique case (state_q)
        StIdle: begin
          if (accept && is_multi) begin
            state_q      <= (alu_op == OpMulu) ? StMul : StDiv;
            busy_q       <= 1'b1;
            cnt_q        <= '0;
            acc_q        <= {32'b0, read_data_1};
            opb_q        <= op_b;
            pend_ctrl_q  <= ctrl_in;
            pend_wreg_q  <= write_reg_in;
            pend_wdata_q <= read_data_2;
          end else if (accept) begin
            out_valid_q <= 1'b1;
            result_q    <= alu_res;
            zero_q      <= (alu_res == 32'd0);
            ctrl_q      <= ctrl_in;
            wreg_q      <= write_reg_in;
            wdata_q     <= read_data_2;
          end
        end
        StMul, StDiv: begin
          acc_q <= step_next;
          cnt_q <= cnt_q + 6'd1;
          if (last_iter) begin
            state_q     <= StIdle;
            busy_q      <= 1'b0;
            cnt_q       <= '0;
            hi_q        <= step_next[63:32];
            lo_q        <= step_next[31:0];
            out_valid_q <= 1'b1;
            result_q    <= step_next[31:0];
            zero_q      <= (step_next[31:0] == 32'd0);
            ctrl_q      <= pend_ctrl_q;
            wreg_q      <= pend_wreg_q;
            wdata_q     <= pend_wdata_q;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign busy                = busy_q;
  assign out_valid           = out_valid_q;
  assign mem_address         = result_q;
  assign zero                = zero_q;
  assign write_data_into_mem = wdata_q;
  assign ctrl_branch         = ctrl_q[4];
  assign ctrl_memRead        = ctrl_q[3];
  assign ctrl_memWrite       = ctrl_q[2];
  assign ctrl_regWrite       = ctrl_q[1];
  assign ctrl_memToReg       = ctrl_q[0];
  assign write_reg           = wreg_q;

endmodule

// File: doc/execute_stage.md
EXECUTE_STAGE -- requirements
Module: execute_stage

Interface
REQ-001 The block SHALL have one clock and an asynchronous active-low reset, named as follows:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous active-low reset
REQ-002 Input ports SHALL be:
- in_valid  input  1  operands and controls valid
- flush  input  1  synchronous cancel
- alu_op  input  4  operation code
- read_data_1  input  32  rs operand
- read_data_2  input  32  rt operand; also store data
- sign_ext_imm  input  32  immediate
- shamt  input  5  shift amount
- ctrl_aluSrc  input  1  1 selects sign_ext_imm as operand B
- ctrl_branch_in, ctrl_memRead_in, ctrl_memWrite_in, ctrl_regWrite_in, ctrl_memToReg_in  input  1 each  decoded controls
- write_reg_in  input  5  destination register
REQ-003 Output ports SHALL be:
- busy  output  1  multi-cycle op in flight; upstream holds its inputs
- out_valid  output  1  result registers valid this cycle
- mem_address  output  32  ALU result; feeds memory_access
- zero  output  1  registered (result == 0)
- write_data_into_mem  output  32  registered read_data_2
- ctrl_branch, ctrl_memRead, ctrl_memWrite, ctrl_regWrite, ctrl_memToReg  output  1 each  registered controls
- write_reg  output  5  registered destination

Function
REQ-004 Operand B SHALL be sign_ext_imm when ctrl_aluSrc=1, else read_data_2.
REQ-005 alu_op encoding SHALL be: 0000 AND, 0001 OR, 0010 ADD (wrapping, no overflow trap), 0110 SUB (wrapping), 0111 SLT (signed, result 0/1), 1100 NOR, 0011 SLL B by shamt, 0100 SRL, 0101 SRA, 1000 MULTU, 1001 DIVU, 1010 MFHI, 1011 MFLO; any other code SHALL yield result 0.
REQ-006 Accept SHALL occur on a rising edge with in_valid=1, busy=0, flush=0.
REQ-007 Single-cycle ops (all except MULTU/DIVU) SHALL register result and controls on the accept edge; out_valid=1 for the following cycle (latency 1).
REQ-008 FSM states SHALL be IDLE, MUL, DIV; accepting MULTU/DIVU SHALL move IDLE->MUL/DIV and set busy=1 on that edge.
REQ-009 MUL SHALL be unsigned shift-add, one bit per cycle; DIV SHALL be unsigned restoring, one quotient bit per cycle; a 6-bit counter SHALL count 32 iterations.
REQ-010 On the 32nd iteration edge (33rd edge counting the accept edge) the block SHALL write HI/LO (MULTU: HI=product[63:32], LO=product[31:0]; DIVU: LO=quotient, HI=remainder), return to IDLE, clear busy, and set out_valid=1 with mem_address=LO and the controls captured at accept.
REQ-011 DIVU with divisor 0 SHALL take the same 33-edge latency and yield LO=0xFFFFFFFF, HI=dividend.
REQ-012 MFHI/MFLO SHALL return HI/LO as updated by all previously completed MULTU/DIVU ops.
REQ-013 in_valid while busy=1 SHALL be ignored; no new accept in the edge that completes a multi-cycle op.
REQ-014 When out_valid=0, ctrl_branch, ctrl_memRead, ctrl_memWrite, ctrl_regWrite SHALL be 0; other data outputs SHALL hold their last values.
REQ-015 flush=1 SHALL, on the next edge, force IDLE, busy=0, out_valid=0, leave HI/LO unchanged, and block acceptance that edge.
REQ-016 zero SHALL be computed from the registered result for every op.

Reset
REQ-017 reset=0 SHALL immediately set state IDLE, counter 0, HI=LO=0, busy=0, out_valid=0, and all data/control outputs 0, including mid-operation.
REQ-018 Release of reset SHALL take effect at the first rising edge with reset=1; no op is accepted before that edge.

Verification
REQ-019 ADD 5+7, aluSrc=0 -> next cycle mem_address=12, zero=0, out_valid=1.
REQ-020 SUB 9-9, ctrl_branch_in=1 -> next cycle mem_address=0, zero=1, ctrl_branch=1.
REQ-021 MULTU 0xFFFFFFFF*2 then MFLO, MFHI -> busy for 32 cycles, out_valid on 33rd edge; MFLO=0xFFFFFFFE, MFHI=0x00000001.
REQ-022 DIVU 100/7 -> LO=14, HI=2; DIVU 100/0 -> LO=0xFFFFFFFF, HI=100, same latency.
REQ-023 Reset pulse at iteration 10 of a MULTU -> busy=0, out_valid=0, HI=LO=0 immediately; next ADD accepted normally.
REQ-024 flush during DIVU at iteration 5 -> idle next edge, no out_valid, HI/LO keep prior values; ctrl_memWrite stays 0 throughout.
